// File: rtl/seg7_capture_decoder.sv
// Recovers BCD digits from a multiplexed active-low 4-digit seven-segment bus.
// Each anode/cathode pattern must stay stable for STABLE_CYCLES samples before capture.
module seg7_capture_decoder #(
   parameter int STABLE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   output logic [15:0] digits,
   output logic [3:0]  valid,
   output logic [3:0]  invalid,
   output logic        digit_upd,
   output logic        frame_done
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   state_t           state;
   logic [3:0]       an_p0, an_s, ref_an;
   logic [6:0]       seg_p0, seg_s, ref_seg;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       seen;

   logic             sel, match, start, cap;
   logic [1:0]       cap_idx;
   logic [4:0]       cap_dec;
   logic [3:0]       seen_nxt;

   // Returns {decodable, bcd}; undecodable patterns map to 4'hF.
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'b0000001: return 5'b1_0000;
         7'b1001111: return 5'b1_0001;
         7'b0010010: return 5'b1_0010;
         7'b0000110: return 5'b1_0011;
         7'b1001100: return 5'b1_0100;
         7'b0100100: return 5'b1_0101;
         7'b0100000: return 5'b1_0110;
         7'b0001111: return 5'b1_0111;
         7'b0000000: return 5'b1_1000;
         7'b0000100: return 5'b1_1001;
         default:    return 5'b0_1111;
      endcase
   endfunction

   function automatic logic single_sel(input logic [3:0] a);
      logic [3:0] n;
      n = ~a;
      return (n != 4'd0) && ((n & (n - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] sel_index(input logic [3:0] a);
      case (a)
         4'b1110: return 2'd0;
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   // Stage 0/1: two-flop synchronizers on the asynchronous display bus
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_p0  <= 4'hF;
         an_s   <= 4'hF;
         seg_p0 <= 7'h7F;
         seg_s  <= 7'h7F;
      end else begin
         an_p0  <= an;
         an_s   <= an_p0;
         seg_p0 <= seg;
         seg_s  <= seg_p0;
      end
   end

   always_comb begin
      sel      = single_sel(an_s);
      match    = ({an_s, seg_s} == {ref_an, ref_seg});
      start    = 1'b0;
      cap      = 1'b0;
      cap_idx  = sel_index(an_s);
      cap_dec  = decode(seg_s);
      seen_nxt = seen | (4'b0001 << cap_idx);
      case (state)
         IDLE: start = sel;
         SETTLE, HOLD: begin
            if (!match) start = sel;
            else if (state == SETTLE && cnt == CNT_LAST) cap = 1'b1;
         end
         default: start = 1'b0;
      endcase
      // A one-cycle window captures on the very first sample of a new pattern.
      if (start && STABLE_CYCLES == 1) cap = 1'b1;
   end

   // Stage 2: settle FSM and capture registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ref_an     <= 4'hF;
         ref_seg    <= 7'h7F;
         cnt        <= '0;
         seen       <= 4'd0;
         digits     <= 16'hFFFF;
         valid      <= 4'd0;
         invalid    <= 4'd0;
         digit_upd  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         digit_upd  <= cap;
         frame_done <= 1'b0;

         if (start) begin
            ref_an  <= an_s;
            ref_seg <= seg_s;
            cnt     <= CNT_ONE;
            state   <= cap ? HOLD : SETTLE;
         end else if (state != IDLE && !match) begin
            state <= IDLE;
         end else if (cap) begin
            state <= HOLD;
         end else if (state == SETTLE && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
         end

         if (cap) begin
            digits[{cap_idx, 2'b00} +: 4] <= cap_dec[3:0];
            valid[cap_idx]                <= cap_dec[4];
            invalid[cap_idx]              <= ~cap_dec[4];
            if (seen_nxt == 4'hF) begin
               frame_done <= 1'b1;
               seen       <= 4'd0;
            end else begin
               seen <= seen_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder: a run-length reference model checked every cycle,
// plus literal expectations for the scenarios of interest.
module tb_seg7_capture_decoder;

   localparam int S = 16;

   logic        clk;
   logic        rst_n;
   logic [3:0]  an_pin;
   logic [6:0]  seg_pin;
   logic [15:0] digits;
   logic [3:0]  valid;
   logic [3:0]  invalid;
   logic        digit_upd;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   seg7_capture_decoder #(.STABLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .an(an_pin), .seg(seg_pin),
      .digits(digits), .valid(valid), .invalid(invalid),
      .digit_upd(digit_upd), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the bus is seen two edges late; a single-digit pattern is captured
   // on the sample where it has been seen identically S times in a row.
   logic [10:0] hist [2];
   logic [10:0] m_prev;
   int          m_run;
   logic [15:0] m_digits;
   logic [3:0]  m_valid, m_invalid, m_seen;
   logic        m_upd, m_fd;
   logic [6:0]  pat [10];

   initial begin
      pat[0] = 7'b0000001; pat[1] = 7'b1001111; pat[2] = 7'b0010010; pat[3] = 7'b0000110;
      pat[4] = 7'b1001100; pat[5] = 7'b0100100; pat[6] = 7'b0100000; pat[7] = 7'b0001111;
      pat[8] = 7'b0000000; pat[9] = 7'b0000100;
   end

   always @(posedge clk or negedge rst_n) begin
      logic [10:0] in;
      int idx, val;
      if (!rst_n) begin
         hist[0] = '1; hist[1] = '1; m_prev = '1; m_run = 0;
         m_digits = 16'hFFFF; m_valid = 0; m_invalid = 0; m_seen = 0;
         m_upd = 0; m_fd = 0;
      end else begin
         in = hist[1];
         hist[1] = hist[0];
         hist[0] = {an_pin, seg_pin};
         if (in == m_prev) m_run++; else m_run = 1;
         m_prev = in;
         m_upd = 0;
         m_fd  = 0;
         if ($countones(~in[10:7]) == 1 && m_run == S) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (!in[7+i]) idx = i;
            val = -1;
            for (int v = 0; v < 10; v++) if (pat[v] == in[6:0]) val = v;
            if (val >= 0) begin
               m_digits[idx*4 +: 4] = 4'(val);
               m_valid[idx] = 1; m_invalid[idx] = 0;
            end else begin
               m_digits[idx*4 +: 4] = 4'hF;
               m_valid[idx] = 0; m_invalid[idx] = 1;
            end
            m_upd = 1;
            m_seen[idx] = 1;
            if (m_seen == 4'hF) begin
               m_fd = 1;
               m_seen = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("cyc_digits", digits, m_digits);
         check("cyc_valid", valid, m_valid);
         check("cyc_invalid", invalid, m_invalid);
         check("cyc_digit_upd", digit_upd, m_upd);
         check("cyc_frame_done", frame_done, m_fd);
      end
   end

   // Event counters, read by the stimulus only on falling edges.
   int upd_cnt, fd_cnt, fd_at, fd_alone;
   logic saw2;
   always @(posedge clk) begin
      #1;
      if (digit_upd) upd_cnt++;
      if (frame_done) begin
         fd_cnt++;
         fd_at = upd_cnt;
         if (!digit_upd) fd_alone++;
      end
      if (digits[7:4] == 4'd2) saw2 = 1'b1;
   end

   task automatic clear_counts();
      upd_cnt = 0; fd_cnt = 0; fd_at = 0; fd_alone = 0; saw2 = 1'b0;
   endtask

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      @(negedge clk);
      an_pin  = a;
      seg_pin = s;
      repeat (n) @(posedge clk);
   endtask

   task automatic measure(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!digit_upd && n < 100);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      logic [15:0] snap_d;
      logic [3:0]  snap_v, snap_i;
      rst_n = 1'b0; an_pin = 4'hF; seg_pin = 7'h7F;
      clear_counts();
      repeat (3) @(negedge clk);
      check("rst_digits", digits, 16'hFFFF);
      check("rst_valid", valid, 4'h0);
      check("rst_invalid", invalid, 4'h0);
      check("rst_upd", digit_upd, 1'b0);
      check("rst_fd", frame_done, 1'b0);
      rst_n = 1'b1;

      hold(4'hF, 7'h7F, 40);
      @(negedge clk);
      check("idle_no_capture", upd_cnt, 0);

      // Basic capture of digit 0 showing 7
      clear_counts();
      an_pin = 4'b1110; seg_pin = 7'b0001111;
      measure(n);
      check("basic_latency", n, 18);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("basic_digit0", digits[3:0], 4'd7);
      check("basic_valid", valid, 4'b0001);
      check("basic_invalid", invalid, 4'b0000);
      check("basic_upd_count", upd_cnt, 1);

      // Glitch rejection on digit 1
      clear_counts();
      hold(4'b1101, 7'b0010010, 10);
      hold(4'b1101, 7'b0000110, 20);
      @(negedge clk);
      check("glitch_upd_count", upd_cnt, 1);
      check("glitch_digit1", digits[7:4], 4'd3);
      check("glitch_no_two", saw2, 1'b0);

      // Invalid pattern then valid pattern on digit 2
      clear_counts();
      hold(4'b1011, 7'b1111111, 20);
      @(negedge clk);
      check("inv_digit2", digits[11:8], 4'hF);
      check("inv_valid2", valid[2], 1'b0);
      check("inv_invalid2", invalid[2], 1'b1);
      check("inv_upd_count", upd_cnt, 1);
      hold(4'b1011, 7'b0100100, 20);
      @(negedge clk);
      check("rec_digit2", digits[11:8], 4'd5);
      check("rec_valid2", valid[2], 1'b1);
      check("rec_invalid2", invalid[2], 1'b0);

      // Several anodes low: no capture
      snap_d = digits; snap_v = valid; snap_i = invalid;
      clear_counts();
      hold(4'b1100, 7'b0000000, 100);
      @(negedge clk);
      check("multi_no_upd", upd_cnt, 0);
      check("multi_digits", digits, snap_d);
      check("multi_valid", valid, snap_v);
      check("multi_invalid", invalid, snap_i);

      // One sample short of the window, then released: no capture
      clear_counts();
      hold(4'b0111, 7'b0000000, S - 1);
      hold(4'hF, 7'h7F, 10);
      @(negedge clk);
      check("short_no_upd", upd_cnt, 0);
      check("short_digit3", digits[15:12], 4'hF);

      // Asynchronous reset mid-settle discards the pending capture
      hold(4'b0111, 7'b0000000, 8);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_digits", digits, 16'hFFFF);
      check("midrst_valid", valid, 4'h0);
      check("midrst_invalid", invalid, 4'h0);
      check("midrst_upd", digit_upd, 1'b0);
      @(negedge clk);
      clear_counts();
      rst_n = 1'b1;
      measure(n);
      check("midrst_latency", n, 18);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("midrst_digit3", digits[15:12], 4'd8);
      check("midrst_valid_after", valid, 4'b1000);
      check("midrst_upd_count", upd_cnt, 1);

      // Full frame from a clean reset
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      clear_counts();
      hold(4'b1110, 7'b1001111, 20);
      hold(4'b1101, 7'b0010010, 20);
      hold(4'b1011, 7'b0000110, 20);
      hold(4'b0111, 7'b1001100, 20);
      hold(4'hF, 7'h7F, 4);
      @(negedge clk);
      check("frame_digits", digits, 16'h4321);
      check("frame_upd_count", upd_cnt, 4);
      check("frame_fd_count", fd_cnt, 1);
      check("frame_fd_on_fourth", fd_at, 4);
      check("frame_fd_alone", fd_alone, 0);

      // Second scan repeating digit 0 first: frame only once digit 3 arrives
      clear_counts();
      hold(4'b1110, 7'b0000001, 20);
      hold(4'b1110, 7'b1001111, 20);
      hold(4'b1101, 7'b0010010, 20);
      hold(4'b1011, 7'b0000110, 20);
      @(negedge clk);
      check("scan2_upd_count", upd_cnt, 4);
      check("scan2_no_early_fd", fd_cnt, 0);
      hold(4'b0111, 7'b0000100, 20);
      @(negedge clk);
      check("scan2_fd_count", fd_cnt, 1);
      check("scan2_digits", digits, 16'h9321);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_capture_decoder.md
# seg7_capture_decoder

Monitors a multiplexed 4-digit, active-low seven-segment bus (anodes plus cathodes) and recovers the displayed digits as BCD. Each anode/cathode pair must hold steady for a settle window before the block decodes it. It sits beside the display drivers as a self-check and readback block for the cathode encoders, and for test benches. Four BCD registers, per-digit valid/invalid flags, an update strobe and a frame-complete strobe are produced.

## Interface
- STABLE_CYCLES, 16: consecutive identical synchronized samples required before capture; legal range 1..65535.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- an  input  4  anode enables, active-low; bit i selects digit i.
- seg  input  7  cathodes, active-low; bit6=a, bit5=b … bit0=g.
- digits  output  16  BCD digits; digits[4i+3:4i] = digit i.
- valid  output  4  bit i set when digit i holds a decoded value.
- invalid  output  4  bit i set when the last capture on digit i was an undecodable pattern.
- digit_upd  output  1  one-cycle pulse on any capture.
- frame_done  output  1  one-cycle pulse when all four digits have been captured since the last pulse.

## Operation
- Input path: `an` and `seg` each pass through a 2-flop synchronizer. All logic below uses the synchronized values `an_s` and `seg_s`.
- Decode table for `seg_s`, giving the digit value:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4
  - 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9
  - Any other value, including blank 1111111, is invalid.
- Single-digit select: exactly one bit of `an_s` is 0. Zero or several low bits means no select.
- FSM with three states:
  - IDLE: wait for a single-digit select. When one appears, latch `{an_s, seg_s}` as the reference, load cnt=1, and go to SETTLE.
  - SETTLE: each cycle, compare `{an_s, seg_s}` with the reference.
    - Mismatch, still a single-digit select: reload the reference, cnt=1, stay in SETTLE.
    - Mismatch, no select: go to IDLE.
    - Match: cnt++. When cnt reaches STABLE_CYCLES, capture and go to HOLD.
  - HOLD: stay while `{an_s, seg_s}` equals the reference. Any change behaves exactly as a SETTLE mismatch. The same pattern is never captured twice in a row.
- Capture on digit i:
  - Valid pattern: digit i ← decoded value; valid[i]=1; invalid[i]=0.
  - Invalid pattern: digit i ← 4'hF; valid[i]=0; invalid[i]=1.
  - In both cases: digit_upd=1 for one cycle, and seen[i]=1.
- Frame tracking: `seen` is a 4-bit mask. On the cycle it would become 4'b1111, frame_done pulses and `seen` clears to 0. Recapturing an already-seen digit does not change `seen`.
- When STABLE_CYCLES=1, capture occurs on the first cycle a single-digit select is present, from IDLE or after a change.
- Counter width is clog2(STABLE_CYCLES+1). The counter saturates and never wraps.

## Timing
- Reset values (immediate on rst_n low, independent of clk):
  - digits=16'hFFFF, valid=0, invalid=0, digit_upd=0, frame_done=0.
  - seen=0, FSM=IDLE, synchronizers=all ones.
- Latency: suppose the pins change before edge k and then hold.
  - `an_s`/`seg_s` reflect the new value after edge k+1.
  - The capture registers, digit_upd and frame_done update at edge k+1+STABLE_CYCLES.
- digit_upd and frame_done are registered, never combinational. They may assert in the same cycle.
- A change occurring on the very cycle cnt would reach STABLE_CYCLES cancels the capture.
- Reset asserted mid-SETTLE or mid-HOLD discards the pending capture. After release, the block starts in IDLE, and the first capture needs a full settle window.

## Test plan
- Reset: drive rst_n=0 asynchronously mid-cycle → digits=FFFF, valid=0, invalid=0, no strobes; after release, with an=1111, no capture ever occurs.
- Basic capture, STABLE_CYCLES=16: an=1110, seg=0001111 held → exactly one digit_upd, 18 edges after the pin change; digits[3:0]=7; valid=0001; invalid=0000.
- Glitch rejection: pattern 0010010 held 10 cycles, then 0000110 held 20 cycles on an=1101 → single capture, digits[7:4]=3; value 2 never appears.
- Invalid pattern: an=1011, seg=1111111 held → digits[11:8]=F, valid[2]=0, invalid[2]=1; a following 0100100 capture → digits[11:8]=5, invalid[2]=0, valid[2]=1.
- Multiple anodes: an=1100 with a valid seg held 100 cycles → no digit_upd, outputs unchanged.
- Full frame: scan digits 0..3 showing 1,2,3,4, each held 20 cycles → digits=16'h4321; four digit_upd pulses; frame_done on the fourth, coincident with it. Repeating digit 0 first in a second scan gives no early frame_done.
